// File: rtl/ps2_pkg.sv
// Shared constants and frame state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a sampled run-length filter; idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8,
  parameter int SAMPLE_DIV = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic line_i,
  output logic filt_o
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync2_q, filt_q;
  logic [DW-1:0] div_q;
  logic [RW-1:0] run_q;
  logic          tick;

  assign tick   = (div_q == '0);
  assign filt_o = filt_q;

  // run_q counts consecutive samples that disagree with the current output
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      div_q   <= '0;
      run_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      div_q   <= tick ? DW'(SAMPLE_DIV - 1) : div_q - 1'b1;
      if (tick) begin
        if (sync2_q == filt_q) begin
          run_q <= '0;
        end else if (run_q == RW'(FILTER_LEN - 1)) begin
          filt_q <= sync2_q;
          run_q  <= '0;
        end else begin
          run_q <= run_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: filtered deframing, parity/stop checks, F0 break folding,
// and a show-ahead FIFO of {release, scan code} entries.
//
// state  | meaning
// IDLE   | waiting for a start bit on the next filtered clock fall
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then queue or flag
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int SAMPLE_DIV  = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  input  logic       iPop,
  input  logic       iClrErr,
  output logic [7:0] oKey,
  output logic       oRelease,
  output logic       oKeyValid,
  output logic       oParityErr,
  output logic       oFrameErr,
  output logic       oOverflow
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  logic clk_f, data_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .SAMPLE_DIV(SAMPLE_DIV)) u_clk_filt (
    .Clock(Clock), .Reset(Reset), .line_i(iPS2Clk), .filt_o(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .SAMPLE_DIV(SAMPLE_DIV)) u_data_filt (
    .Clock(Clock), .Reset(Reset), .line_i(iPS2Data), .filt_o(data_f)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          brk_q, brk_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          clk_prev_q, fall_q;
  logic          perr_q, perr_d, ferr_q, ferr_d;
  logic          push_q, push_d;
  logic [8:0]    push_data_q, push_data_d;
  logic          timeout;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          ovf_q;
  logic          empty, full, pop_ok, push_ok;

  assign timeout = (state_q != IDLE) && !fall_q && (tmr_q == '0);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    brk_d       = brk_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    tmr_d       = tmr_q;

    if (fall_q) begin
      tmr_d = TW'(TIMEOUT_CYC - 1);
    end else if (state_q != IDLE && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end

    if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b0;
          end
        end
        DATA: begin
          shift_d  = {data_f, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_f;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_f) begin
            ferr_d = 1'b1;
            brk_d  = 1'b0;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
            brk_d  = 1'b0;
          end else if (shift_q == PS2_BREAK) begin
            brk_d = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_data_d = {brk_q, shift_q};
            brk_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      brk_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      brk_q       <= 1'b0;
      tmr_q       <= '0;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      brk_q       <= brk_d;
      tmr_q       <= tmr_d;
      clk_prev_q  <= clk_f;
      fall_q      <= clk_prev_q & ~clk_f;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = iPop && !empty;
  assign push_ok = push_q && (!full || pop_ok);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_q && !push_ok) ovf_q <= 1'b1;
      else if (iClrErr)       ovf_q <= 1'b0;
    end
  end

  assign oKey       = mem_q[rd_ptr_q[AW-1:0]][7:0];
  assign oRelease   = mem_q[rd_ptr_q[AW-1:0]][8];
  assign oKeyValid  = !empty;
  assign oParityErr = perr_q;
  assign oFrameErr  = ferr_q;
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: bit-banged PS/2 frames, hand-computed results.
module tb_ps2_key_receiver;

  localparam int TMO = 1000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iPS2Clk = 1'b1;
  logic       iPS2Data = 1'b1;
  logic       iPop = 1'b0;
  logic       iClrErr = 1'b0;
  logic [7:0] oKey;
  logic       oRelease, oKeyValid, oParityErr, oFrameErr, oOverflow;

  int vectors = 0;
  int miscompares = 0;
  int perr_cycles = 0;
  int ferr_cycles = 0;
  int perr_base, ferr_base;

  ps2_key_receiver #(
    .FILTER_LEN(8), .SAMPLE_DIV(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iPS2Clk(iPS2Clk), .iPS2Data(iPS2Data),
    .iPop(iPop), .iClrErr(iClrErr), .oKey(oKey), .oRelease(oRelease),
    .oKeyValid(oKeyValid), .oParityErr(oParityErr), .oFrameErr(oFrameErr),
    .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (oParityErr === 1'b1) perr_cycles++;
    if (oFrameErr === 1'b1)  ferr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Sends the first nbits of an 11-bit frame; glitch_bit >= 0 injects a 3-cycle clock low after that bit
  task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      iPS2Data = frame[i];
      cycles(15);
      iPS2Clk = 1'b0;
      cycles(30);
      iPS2Clk = 1'b1;
      if (i == glitch_bit) begin
        cycles(5);
        iPS2Clk = 1'b0;
        cycles(3);
        iPS2Clk = 1'b1;
        cycles(7);
      end else begin
        cycles(15);
      end
    end
    iPS2Data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_key(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0, 1'b1), 11, -1);
    cycles(40);
  endtask

  task automatic pop();
    iPop = 1'b1;
    cycles(1);
    iPop = 1'b0;
  endtask

  task automatic mark();
    perr_base = perr_cycles;
    ferr_base = ferr_cycles;
  endtask

  initial begin
    cycles(3);
    check("rst_key",     oKey,       8'h00);
    check("rst_rel",     oRelease,   1'b0);
    check("rst_valid",   oKeyValid,  1'b0);
    check("rst_perr",    oParityErr, 1'b0);
    check("rst_ferr",    oFrameErr,  1'b0);
    check("rst_ovf",     oOverflow,  1'b0);
    Reset = 1'b1;
    cycles(40);

    mark();
    send_key(8'h1C);
    check("k1c_valid", oKeyValid, 1'b1);
    check("k1c_key",   oKey,      8'h1C);
    check("k1c_rel",   oRelease,  1'b0);
    check("k1c_nerr",  (perr_cycles - perr_base) + (ferr_cycles - ferr_base), 0);
    pop();
    check("k1c_popped", oKeyValid, 1'b0);

    send_key(8'hF0);
    check("brk_noqueue", oKeyValid, 1'b0);
    send_key(8'h1C);
    check("brk_valid", oKeyValid, 1'b1);
    check("brk_key",   oKey,      8'h1C);
    check("brk_rel",   oRelease,  1'b1);
    pop();
    check("brk_single", oKeyValid, 1'b0);
    send_key(8'h32);
    check("k32_key", oKey,     8'h32);
    check("k32_rel", oRelease, 1'b0);
    pop();

    mark();
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, -1);
    cycles(40);
    check("par_pulse", perr_cycles - perr_base, 1);
    check("par_empty", oKeyValid, 1'b0);
    mark();
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11, -1);
    cycles(40);
    check("stop_pulse", ferr_cycles - ferr_base, 1);
    check("stop_nopar", perr_cycles - perr_base, 0);
    check("stop_empty", oKeyValid, 1'b0);

    mark();
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 4);
    cycles(40);
    check("glitch_key",  oKey,      8'h1C);
    check("glitch_valid", oKeyValid, 1'b1);
    check("glitch_nerr", (perr_cycles - perr_base) + (ferr_cycles - ferr_base), 0);
    pop();

    send_key(8'h15);
    send_key(8'h16);
    send_key(8'h17);
    send_key(8'h18);
    check("ovf_before", oOverflow, 1'b0);
    send_key(8'h19);
    check("ovf_set",  oOverflow, 1'b1);
    check("ovf_head", oKey,      8'h15);
    check("ovf_q0", oKey, 8'h15); pop();
    check("ovf_q1", oKey, 8'h16); pop();
    check("ovf_q2", oKey, 8'h17); pop();
    check("ovf_q3", oKey, 8'h18); pop();
    check("ovf_drained", oKeyValid, 1'b0);
    check("ovf_sticky",  oOverflow, 1'b1);
    iClrErr = 1'b1;
    cycles(1);
    iClrErr = 1'b0;
    check("ovf_cleared", oOverflow, 1'b0);

    mark();
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5, -1);
    cycles(TMO / 2);
    check("tmo_early", ferr_cycles - ferr_base, 0);
    cycles(TMO);
    check("tmo_pulse", ferr_cycles - ferr_base, 1);
    check("tmo_empty", oKeyValid, 1'b0);
    send_key(8'h2A);
    check("tmo_next_key",   oKey,      8'h2A);
    check("tmo_next_valid", oKeyValid, 1'b1);
    pop();

    send_key(8'h1C);
    send_bits(mk_frame(8'h2A, 1'b0, 1'b1), 4, -1);
    Reset = 1'b0;
    iPS2Clk = 1'b1;
    iPS2Data = 1'b1;
    cycles(2);
    check("mrst_valid", oKeyValid, 1'b0);
    check("mrst_key",   oKey,      8'h00);
    check("mrst_rel",   oRelease,  1'b0);
    check("mrst_errs",  {oParityErr, oFrameErr, oOverflow}, 3'b000);
    cycles(5);
    Reset = 1'b1;
    cycles(40);
    mark();
    send_key(8'h2A);
    check("mrst_next_key",   oKey,      8'h2A);
    check("mrst_next_valid", oKeyValid, 1'b1);
    check("mrst_next_nerr",  (perr_cycles - perr_base) + (ferr_cycles - ferr_base), 0);
    pop();
    check("mrst_next_single", oKeyValid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

PS/2 keyboard front end that turns the raw `PS2_CLK`/`PS2_DATA` pins into validated scan codes for the CPU's `TEC` instruction path. It synchronises and de-glitches both lines, deframes 11-bit PS/2 frames, checks odd parity and the stop bit, and folds `F0` break prefixes into a release flag. Each result is queued in a small show-ahead FIFO that the core pops.

## Interface

Parameters:
- `FILTER_LEN`, 8: consecutive equal samples needed before a filtered line changes.
- `SAMPLE_DIV`, 2: number of `Clock` cycles per filter sample.
- `FIFO_DEPTH`, 4: queued entries; must be a power of 2, at least 2.
- `TIMEOUT_CYC`, 50000: maximum `Clock` cycles between frame bits before the frame is aborted.

Ports:
- `Clock`, in, 1: system clock.
- `Reset`, in, 1: asynchronous, active-low reset.
- `iPS2Clk`, in, 1: raw keyboard clock pin.
- `iPS2Data`, in, 1: raw keyboard data pin.
- `iPop`, in, 1: consume the FIFO head. Ignored when `oKeyValid` is 0.
- `iClrErr`, in, 1: clears `oOverflow`.
- `oKey`, out, 8: scan code at the FIFO head.
- `oRelease`, out, 1: head entry was preceded by `F0`.
- `oKeyValid`, out, 1: FIFO is not empty.
- `oParityErr`, out, 1: one-cycle pulse on a parity failure.
- `oFrameErr`, out, 1: one-cycle pulse on a bad start bit, bad stop bit or timeout.
- `oOverflow`, out, 1: sticky flag; a code was dropped because the FIFO was full.

## Operation

Line conditioning:
- Each pin passes through a 2-flop synchroniser, then a filter.
- The filter takes a sample every `SAMPLE_DIV` cycles. Its output changes only after `FILTER_LEN` consecutive equal samples.
- The receiver acts on a falling edge of the filtered clock (a registered compare of the filter output with its previous value).

Frame state machine (advances on each filtered falling edge):
- `IDLE`:
  - Data = 0 → `DATA`, bit counter = 0.
  - Data = 1 → assert `oFrameErr`, stay in `IDLE`.
- `DATA`: shift the bit in, LSB first. After the 8th bit → `PARITY`.
- `PARITY`: latch the parity bit → `STOP`.
- `STOP`: evaluate the frame, then return to `IDLE`.
  - Stop bit = 0 → `oFrameErr`.
  - Else, if (ones in data + parity bit) is even → `oParityErr`.
  - Else the byte is good.
- Timeout: in any state other than `IDLE`, a cycle counter restarts on each falling edge. Reaching `TIMEOUT_CYC` → `oFrameErr`, return to `IDLE`, discard partial data.

Good-byte handling:
- Byte `F0`: set the internal `brk` flag; nothing is queued.
- Any other byte (including `E0`): push `{brk, byte}` into the FIFO, then clear `brk`.
- An error frame clears `brk`.

FIFO (show-ahead):
- `oKey`/`oRelease` always show the head entry. `oKeyValid` = not empty.
- Push when full: the new entry is dropped and `oOverflow` is set.
- Push and pop in the same cycle when full: both take effect; no overflow.
- Pointer width is log2(`FIFO_DEPTH`)+1, and pointers wrap naturally.
- `iClrErr` clears `oOverflow`. If `iClrErr` coincides with a new overflow, the overflow wins.

Reset:
- All outputs go to 0, the FSM goes to `IDLE`, the FIFO empties, `brk` = 0.
- Filter outputs reset to 1 (idle line level).
- Reset mid-frame discards the frame.

## Timing

- Pin edge to filtered edge: 2 cycles of synchronisation, plus `FILTER_LEN`×`SAMPLE_DIV` cycles, plus up to `SAMPLE_DIV`−1 cycles of phase.
- Error pulses are 1 cycle wide, asserted the cycle after the offending falling edge is detected.
- Push occurs the cycle after the stop-bit edge is detected. `oKeyValid` rises 1 cycle after the push.
- Pop: with `iPop` high at edge N, the head advances and `oKey` shows the next entry after edge N. `oKeyValid` falls after edge N if that was the last entry.
- Outputs are registered or driven directly from FIFO storage and pointers; there is no combinational path from the pins.

## Structure

- A shared package `ps2_pkg` holds:
  - `PS2_BREAK` = 8'hF0.
  - `PS2_FRAME_BITS` = 11.
  - The FSM state encoding (`IDLE`, `DATA`, `PARITY`, `STOP`).
- One sub-module, `ps2_line_filter`: synchroniser plus majority/run-length filter, parameterised by `FILTER_LEN` and `SAMPLE_DIV`, with reset value 1. It is instantiated twice (clock and data).
- The FIFO is inline: a register array plus read/write pointers.

## Test plan

- Send frame `1C` with parity 0 and stop 1 → `oKeyValid`=1, `oKey`=1C, `oRelease`=0. Pulse `iPop` → `oKeyValid`=0.
- Send `F0` then `1C` → exactly one entry, `oKey`=1C, `oRelease`=1. Then send `32` → the next entry has `oRelease`=0.
- Send `1C` with parity 1 → one `oParityErr` pulse, FIFO stays empty. Send `1C` with stop 0 → one `oFrameErr` pulse, FIFO stays empty.
- Add a 3-cycle low glitch on `iPS2Clk` between valid bits of frame `1C` → decoded `oKey`=1C, no errors.
- Send `15 16 17 18 19` with no pop (`FIFO_DEPTH`=4) → four entries, 15..18 in order; `oOverflow`=1 after `19`. Pop four times → 15, 16, 17, 18. Pulse `iClrErr` → `oOverflow`=0.
- Abort frame `1C` after 5 bits, then stay idle → `oFrameErr` after `TIMEOUT_CYC`. A following full `2A` is received correctly.
- Assert `Reset` mid-frame → all outputs 0, FIFO empty. The next full `2A` is received correctly.
